// File: rtl/uart_tx_arbiter.sv
// Frame-atomic two-requester arbiter (A console, B telemetry) in front of uart_tx, with a watchdog.
// Latency: grant 1 cycle after valid in IDLE; byte reaches tx_data/tx_write 1 cycle after x_ready.
// Backpressure: x_ready only in SEND with tx_ready=1; optional UART_TX_ARB_PRIORITY_EN gives A fixed priority.
module uart_tx_arbiter #(
    parameter int MAX_FRAME      = 64,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_ready,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(MAX_FRAME - 1);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        owner_nxt;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic        last_flag, last_nxt;
    logic [7:0]  tx_data_nxt;
    logic        tx_write_nxt;
    logic [15:0] wd_cnt, wd_nxt;
    logic        timeout_nxt;
`ifndef UART_TX_ARB_PRIORITY_EN
    logic        rr_ptr, rr_nxt;
`endif

    logic        sel_valid, sel_last, send_fire, wait_exit, grant_b;
    logic [7:0]  sel_data;

    assign sel_valid = owner ? b_valid : a_valid;
    assign sel_last  = owner ? b_last  : a_last;
    assign sel_data  = owner ? b_data  : a_data;
    assign send_fire = (state == SEND) && tx_ready && sel_valid;
    assign a_ready   = send_fire && !owner;
    assign b_ready   = send_fire && owner;
    assign busy      = (state != IDLE);
    // WAIT_BUSY leaves when uart_tx goes busy, WAIT_DONE when it returns to ready
    assign wait_exit = (state == WAIT_BUSY) ? !tx_ready : tx_ready;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        byte_cnt_nxt = byte_cnt;
        last_nxt     = last_flag;
        tx_data_nxt  = tx_data;
        tx_write_nxt = 1'b0;
        wd_nxt       = wd_cnt;
        timeout_nxt  = 1'b0;
        grant_b      = 1'b0;
`ifndef UART_TX_ARB_PRIORITY_EN
        rr_nxt       = rr_ptr;
`endif
        unique case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
`ifdef UART_TX_ARB_PRIORITY_EN
                    grant_b = !a_valid;
`else
                    grant_b = b_valid && (!a_valid || rr_ptr);
`endif
                    owner_nxt    = grant_b;
                    byte_cnt_nxt = 8'd0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (send_fire) begin
                    tx_data_nxt  = sel_data;
                    tx_write_nxt = 1'b1;
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    last_nxt     = sel_last || (byte_cnt == LAST_IDX);
                    wd_nxt       = 16'd0;
                    state_nxt    = WAIT_BUSY;
                end
            end
            WAIT_BUSY, WAIT_DONE: begin
                wd_nxt = wd_cnt + 16'd1;
                if (wait_exit) begin
                    if (state == WAIT_BUSY) begin
                        state_nxt = WAIT_DONE;
                    end else if (last_flag) begin
                        state_nxt = IDLE;
`ifndef UART_TX_ARB_PRIORITY_EN
                        rr_nxt    = ~owner;
`endif
                    end else begin
                        state_nxt = SEND;
                    end
                end else if (wd_cnt == WD_LIMIT) begin
                    // stuck transmitter: abandon the frame and hand the turn to the other side
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
`ifndef UART_TX_ARB_PRIORITY_EN
                    rr_nxt      = ~owner;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            byte_cnt    <= 8'd0;
            last_flag   <= 1'b0;
            tx_data     <= 8'd0;
            tx_write    <= 1'b0;
            wd_cnt      <= 16'd0;
            timeout_err <= 1'b0;
`ifndef UART_TX_ARB_PRIORITY_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            byte_cnt    <= byte_cnt_nxt;
            last_flag   <= last_nxt;
            tx_data     <= tx_data_nxt;
            tx_write    <= tx_write_nxt;
            wd_cnt      <= wd_nxt;
            timeout_err <= timeout_nxt;
`ifndef UART_TX_ARB_PRIORITY_EN
            rr_ptr      <= rr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural uart_tx model, write logger, per-scenario tasks.
module tb_uart_tx_arbiter;

    localparam int MAXF = 4;
    localparam int TOUT = 32;

    logic       clk, reset_n;
    logic [7:0] a_data, b_data, tx_data;
    logic       a_valid, a_last, a_ready, b_valid, b_last, b_ready;
    logic       tx_write, tx_ready, owner, busy, timeout_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [8:0] log_q[$];
    int   wide_cnt = 0, b_rdy_cnt = 0, to_cnt = 0;
    logic prev_wr = 1'b0;
    logic uart_stuck = 1'b0;

    uart_tx_arbiter #(.MAX_FRAME(MAXF), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_tx model: goes busy 1 cycle after the write strobe, ready again 20 cycles later
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_write === 1'b1) begin
                @(posedge clk); #1 tx_ready = 1'b0;
                repeat (20) @(posedge clk);
                while (uart_stuck) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_write === 1'b1) begin
            log_q.push_back({owner, tx_data});
            if (prev_wr) wide_cnt++;
        end
        if (b_ready === 1'b1) b_rdy_cnt++;
        if (timeout_err === 1'b1) to_cnt++;
        prev_wr = (tx_write === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic apply_reset();
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drive_a(input int n, input logic [7:0] base, input int last_every);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            a_data  = base + 8'(i);
            a_last  = (last_every > 0) && (i % last_every == last_every - 1);
            a_valid = 1'b1;
            @(negedge clk);
            while (a_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
            if (w >= 2000) begin
                n_vec++; n_bad++;
                $display("FAIL drive_a_timeout byte %0d never accepted, a_ready=%b required 1", i, a_ready);
                a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic drive_b(input int n, input logic [7:0] base, input int last_every);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            b_data  = base + 8'(i);
            b_last  = (last_every > 0) && (i % last_every == last_every - 1);
            b_valid = 1'b1;
            @(negedge clk);
            while (b_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
            if (w >= 2000) begin
                n_vec++; n_bad++;
                $display("FAIL drive_b_timeout byte %0d never accepted, b_ready=%b required 1", i, b_ready);
                b_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy !== 1'b0 && w < 500) begin @(negedge clk); w++; end
        n_vec++;
        if (w >= 500) begin
            n_bad++;
            $display("FAIL wait_idle busy=%b required 0 within 500 cycles", busy);
        end
    endtask

    task automatic test_reset();
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00;
        reset_n = 1'b0;
        #2;
        n_vec++; if (tx_write !== 1'b0) begin n_bad++; $display("FAIL rst_tx_write got %b want 0", tx_write); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner got %b want 0", owner); end
        n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
        n_vec++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL idle_ready got %b want 00", {a_ready, b_ready}); end
    endtask

    task automatic test_single_a();
        int l0 = log_q.size();
        int b0 = b_rdy_cnt;
        int wd0 = wide_cnt;
        int w = 0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h041, 9'h042, 9'h043};
        drive_a(3, 8'h41, 3);
        while (tx_ready !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        while (tx_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_vec++; if (w >= 100) begin n_bad++; $display("FAIL single_txready tx_ready=%b never completed cycle", tx_ready); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_hold got %b want 1", busy); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall got %b want 0", busy); end
        n_vec++; if (log_q.size() - l0 !== 3) begin n_bad++; $display("FAIL single_count got %0d want 3", log_q.size() - l0); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL single_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL single_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
        n_vec++; if (wide_cnt !== wd0) begin n_bad++; $display("FAIL single_strobe_width got %0d long strobes want 0", wide_cnt - wd0); end
        n_vec++; if (b_rdy_cnt !== b0) begin n_bad++; $display("FAIL single_b_ready got %0d pulses want 0", b_rdy_cnt - b0); end
    endtask

    task automatic test_contention();
        int l0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h010, 9'h011, 9'h120, 9'h121,
                  9'h030, 9'h031, 9'h150, 9'h151, 9'h032, 9'h033, 9'h152, 9'h153};
        apply_reset();
        l0 = log_q.size();
        fork
            drive_a(2, 8'h10, 2);
            drive_b(2, 8'h20, 2);
        join
        wait_idle();
        fork
            drive_a(4, 8'h30, 2);
            drive_b(4, 8'h50, 2);
        join
        wait_idle();
        n_vec++; if (log_q.size() - l0 !== 12) begin n_bad++; $display("FAIL cont_count got %0d want 12", log_q.size() - l0); end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL cont_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL cont_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_max_frame();
        int l0, t0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h160, 9'h161, 9'h162, 9'h163, 9'h070,
                  9'h164, 9'h165, 9'h166, 9'h167, 9'h071, 9'h168, 9'h169};
        apply_reset();
        l0 = log_q.size();
        t0 = to_cnt;
        fork
            drive_b(10, 8'h60, 0);
            begin repeat (3) @(posedge clk); #1; drive_a(2, 8'h70, 1); end
        join
        repeat (TOUT + 10) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL maxf_stall_busy got %b want 1", busy); end
        n_vec++; if (owner !== 1'b1) begin n_bad++; $display("FAIL maxf_stall_owner got %b want 1", owner); end
        n_vec++; if (to_cnt !== t0) begin n_bad++; $display("FAIL maxf_no_timeout got %0d pulses want 0", to_cnt - t0); end
        n_vec++; if (log_q.size() - l0 !== 12) begin n_bad++; $display("FAIL maxf_count got %0d want 12", log_q.size() - l0); end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL maxf_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL maxf_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_watchdog();
        int l0, t0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h080, 9'h190};
        apply_reset();
        l0 = log_q.size();
        t0 = to_cnt;
        uart_stuck = 1'b1;
        fork
            begin repeat (2) @(posedge clk); #1; drive_b(1, 8'h90, 1); end
            begin
                int cyc = 0;
                drive_a(1, 8'h80, 1);
                while (timeout_err !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
                n_vec++; if (cyc !== TOUT) begin n_bad++; $display("FAIL wd_latency got %0d cycles want %0d", cyc, TOUT); end
                n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_busy_drop got %b want 0", busy); end
                @(posedge clk); #1;
                n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wd_pulse_width got %b want 0", timeout_err); end
                n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wd_regrant_busy got %b want 1", busy); end
                n_vec++; if (owner !== 1'b1) begin n_bad++; $display("FAIL wd_regrant_owner got %b want 1", owner); end
                uart_stuck = 1'b0;
            end
        join
        wait_idle();
        n_vec++; if (to_cnt - t0 !== 1) begin n_bad++; $display("FAIL wd_pulse_count got %0d want 1", to_cnt - t0); end
        n_vec++; if (log_q.size() - l0 !== 2) begin n_bad++; $display("FAIL wd_count got %0d want 2", log_q.size() - l0); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL wd_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL wd_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int l0 = log_q.size();
        int w = 0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h0A0, 9'h1C5, 9'h0B0, 9'h1C0};
        drive_a(1, 8'hA0, 1);
        wait_idle();
        b_data = 8'hC5; b_last = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        while (tx_write !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        n_vec++; if (w >= 2000) begin n_bad++; $display("FAIL rmid_write tx_write=%b never asserted", tx_write); end
        b_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (tx_write !== 1'b0) begin n_bad++; $display("FAIL rmid_tx_write got %b want 0", tx_write); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rmid_owner got %b want 0", owner); end
        a_data = 8'hB0; a_last = 1'b1; a_valid = 1'b1;
        b_data = 8'hC0; b_last = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        w = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && b_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        n_vec++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL rmid_first_grant got a/b ready %b want 10", {a_ready, b_ready}); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rmid_first_owner got %b want 0", owner); end
        @(posedge clk); #1 a_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (b_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        n_vec++; if (w >= 2000) begin n_bad++; $display("FAIL rmid_b_grant b_ready=%b never asserted", b_ready); end
        @(posedge clk); #1 b_valid = 1'b0;
        wait_idle();
        n_vec++; if (log_q.size() - l0 !== 4) begin n_bad++; $display("FAIL rmid_count got %0d want 4", log_q.size() - l0); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL rmid_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL rmid_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
    endtask

`ifdef UART_TX_ARB_PRIORITY_EN
    task automatic test_priority();
        int l0;
        logic [8:0] exp_q[$];
        exp_q = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h0D3, 9'h0D4, 9'h0D5, 9'h0D6, 9'h0D7, 9'h1E0, 9'h1E1};
        apply_reset();
        l0 = log_q.size();
        fork
            drive_a(8, 8'hD0, 8);
            drive_b(2, 8'hE0, 1);
        join
        wait_idle();
        n_vec++; if (log_q.size() - l0 !== 10) begin n_bad++; $display("FAIL prio_count got %0d want 10", log_q.size() - l0); end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (log_q.size() <= l0 + i) begin n_bad++; $display("FAIL prio_byte%0d missing want %h", i, exp_q[i]); end
            else if (log_q[l0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL prio_byte%0d got %h want %h", i, log_q[l0 + i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a();
`ifdef UART_TX_ARB_PRIORITY_EN
        test_priority();
`else
        test_contention();
        test_max_frame();
`endif
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
